// File: rtl/bms_pkg.sv
// Shared types and channel map for the battery-monitor scan path.
// Channel indices: cells first, then pack current, then temperature.
package bms_pkg;

  localparam int ADC_WIDTH_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CONVERT,
    PUBLISH
  } scan_state_t;

  function automatic int CH_CURRENT(input int num_cells);
    return num_cells;
  endfunction

  function automatic int CH_TEMP(input int num_cells);
    return num_cells + 1;
  endfunction

endpackage

// File: rtl/scan_period_timer.sv
// Scan period counter: raises a frame trigger every SCAN_PERIOD cycles
// and flags triggers that land while a frame is pending or in flight.
module scan_period_timer #(
  parameter int SCAN_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic idle,
  input  logic consume,
  output logic pending,
  output logic overrun_pulse
);

  localparam int PW = $clog2(SCAN_PERIOD);

  logic [PW-1:0] cnt;
  logic          wrap;

  assign wrap = enable && (cnt == PW'(SCAN_PERIOD - 1));
  assign overrun_pulse = wrap && (pending || !idle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + PW'(1);
      // a new trigger beats a same-cycle consume so it is not lost
      if (wrap)
        pending <= 1'b1;
      else if (consume)
        pending <= 1'b0;
    end
  end

endmodule

// File: rtl/adc_scan_sequencer.sv
// Shared ADC scan sequencer: walks cells, current and temperature each
// period, then publishes the shadow set atomically with a valid strobe.
module adc_scan_sequencer
  import bms_pkg::*;
#(
  parameter int NUM_CELLS     = 4,
  parameter int ADC_WIDTH     = ADC_WIDTH_DEFAULT,
  parameter int SCAN_PERIOD   = 1000,
  parameter int SETTLE_CYCLES = 4,
  parameter int CONV_TIMEOUT  = 64,
  localparam int CH_W = $clog2(NUM_CELLS + 2)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           enable,
  output logic [CH_W-1:0]                adc_chan_o,
  output logic                           adc_start_o,
  input  logic                           adc_done_i,
  input  logic [ADC_WIDTH-1:0]           adc_data_i,
  output logic [NUM_CELLS*ADC_WIDTH-1:0] cell_voltage_packed_o,
  output logic [ADC_WIDTH-1:0]           current_raw_o,
  output logic [ADC_WIDTH-1:0]           temp_raw_o,
  output logic                           frame_valid_o,
  output logic                           busy_o,
  output logic                           timeout_err_o,
  output logic [CH_W-1:0]                err_chan_o,
  output logic                           overrun_err_o,
  input  logic                           clear_err_i,
  output logic [31:0]                    frame_count_o
);

  localparam int NCH = NUM_CELLS + 2;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int TW  = $clog2(CONV_TIMEOUT + 1);
  localparam int CUR = CH_CURRENT(NUM_CELLS);
  localparam int TMP = CH_TEMP(NUM_CELLS);
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(TMP);

  scan_state_t          state;
  logic [CH_W-1:0]      chan;
  logic [SW-1:0]        settle_cnt;
  logic [TW-1:0]        tmo_cnt;
  logic                 frame_bad;
  logic [ADC_WIDTH-1:0] shadow [NCH];

  logic idle, consume, pending, overrun_pulse;
  logic in_conv, done_ok, tmo_hit;

  assign idle    = (state == IDLE);
  assign consume = idle && pending;
  assign busy_o  = !idle;
  // the start cycle has tmo_cnt == 0, so a done there is ignored
  assign in_conv = enable && (state == CONVERT);
  assign done_ok = in_conv && adc_done_i && (tmo_cnt != '0);
  assign tmo_hit = in_conv && !done_ok &&
                   (tmo_cnt == TW'(CONV_TIMEOUT - 1));

  scan_period_timer #(
    .SCAN_PERIOD(SCAN_PERIOD)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .idle         (idle),
    .consume      (consume),
    .pending      (pending),
    .overrun_pulse(overrun_pulse)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IDLE;
      chan                  <= '0;
      settle_cnt            <= '0;
      tmo_cnt               <= '0;
      frame_bad             <= 1'b0;
      adc_chan_o            <= '0;
      adc_start_o           <= 1'b0;
      cell_voltage_packed_o <= '0;
      current_raw_o         <= '0;
      temp_raw_o            <= '0;
      frame_valid_o         <= 1'b0;
      timeout_err_o         <= 1'b0;
      err_chan_o            <= '0;
      overrun_err_o         <= 1'b0;
      frame_count_o         <= '0;
      for (int i = 0; i < NCH; i++)
        shadow[i] <= '0;
    end else begin
      frame_valid_o <= 1'b0;
      adc_start_o   <= 1'b0;

      if (tmo_hit)
        timeout_err_o <= 1'b1;
      else if (clear_err_i)
        timeout_err_o <= 1'b0;

      if (overrun_pulse)
        overrun_err_o <= 1'b1;
      else if (clear_err_i)
        overrun_err_o <= 1'b0;

      if (!enable) begin
        state <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (pending) begin
              chan       <= '0;
              adc_chan_o <= '0;
              frame_bad  <= 1'b0;
              settle_cnt <= '0;
              state      <= SETTLE;
            end
          end
          SETTLE: begin
            if (settle_cnt == SW'(SETTLE_CYCLES - 1)) begin
              adc_start_o <= 1'b1;
              tmo_cnt     <= '0;
              state       <= CONVERT;
            end else begin
              settle_cnt <= settle_cnt + SW'(1);
            end
          end
          CONVERT: begin
            tmo_cnt <= tmo_cnt + TW'(1);
            if (done_ok || tmo_hit) begin
              if (done_ok) begin
                for (int i = 0; i < NCH; i++)
                  if (chan == CH_W'(i))
                    shadow[i] <= adc_data_i;
              end else begin
                frame_bad  <= 1'b1;
                err_chan_o <= chan;
              end
              if (chan == LAST_CH) begin
                state <= PUBLISH;
              end else begin
                chan       <= chan + CH_W'(1);
                adc_chan_o <= chan + CH_W'(1);
                settle_cnt <= '0;
                state      <= SETTLE;
              end
            end
          end
          PUBLISH: begin
            for (int i = 0; i < NUM_CELLS; i++)
              cell_voltage_packed_o[i*ADC_WIDTH +: ADC_WIDTH] <= shadow[i];
            current_raw_o <= shadow[CUR];
            temp_raw_o    <= shadow[TMP];
            if (!frame_bad) begin
              frame_valid_o <= 1'b1;
              frame_count_o <= frame_count_o + 32'd1;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Directed bench for adc_scan_sequencer with a behavioural ADC model;
// a second short-period instance exercises scan overrun.
module tb_adc_scan_sequencer;

  localparam int NC = 4;
  localparam int W  = 12;
  localparam int SP = 200;
  localparam int ST = 4;
  localparam int CT = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic o_enable = 1'b0;
  logic clear_err = 1'b0;

  logic [2:0]      chan, echan;
  logic            start, done, fv, busy, terr, oerr;
  logic [W-1:0]    data, cur, temp;
  logic [NC*W-1:0] packed_v;
  logic [31:0]     fcnt;

  logic [2:0]      o_chan, o_echan;
  logic            o_start, o_done, o_fv, o_busy, o_terr, o_oerr;
  logic [W-1:0]    o_data, o_cur, o_temp;
  logic [NC*W-1:0] o_packed;
  logic [31:0]     o_fcnt;

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  adc_scan_sequencer #(
    .NUM_CELLS(NC), .ADC_WIDTH(W), .SCAN_PERIOD(SP),
    .SETTLE_CYCLES(ST), .CONV_TIMEOUT(CT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .adc_chan_o(chan), .adc_start_o(start),
    .adc_done_i(done), .adc_data_i(data),
    .cell_voltage_packed_o(packed_v),
    .current_raw_o(cur), .temp_raw_o(temp),
    .frame_valid_o(fv), .busy_o(busy),
    .timeout_err_o(terr), .err_chan_o(echan),
    .overrun_err_o(oerr), .clear_err_i(clear_err),
    .frame_count_o(fcnt)
  );

  adc_scan_sequencer #(
    .NUM_CELLS(NC), .ADC_WIDTH(W), .SCAN_PERIOD(20),
    .SETTLE_CYCLES(ST), .CONV_TIMEOUT(CT)
  ) dut_ov (
    .clk(clk), .rst_n(rst_n), .enable(o_enable),
    .adc_chan_o(o_chan), .adc_start_o(o_start),
    .adc_done_i(o_done), .adc_data_i(o_data),
    .cell_voltage_packed_o(o_packed),
    .current_raw_o(o_cur), .temp_raw_o(o_temp),
    .frame_valid_o(o_fv), .busy_o(o_busy),
    .timeout_err_o(o_terr), .err_chan_o(o_echan),
    .overrun_err_o(o_oerr), .clear_err_i(1'b0),
    .frame_count_o(o_fcnt)
  );

  // ADC model: done k cycles after start (k = dly[chan], 0 = never)
  int         dly [8];
  logic [W-1:0] base;
  int         mk;
  bit         mact;
  always @(posedge clk) begin
    #1;
    if (start) begin
      mact = 1'b1;
      mk = 0;
    end else if (mact) begin
      mk++;
    end
    if (mk > 100) mact = 1'b0;
    done = mact && (dly[chan] != 0) && (mk == dly[chan]);
    if (done) mact = 1'b0;
    data = base + W'(chan);
  end

  int ok;
  bit oact;
  always @(posedge clk) begin
    #1;
    if (o_start) begin
      oact = 1'b1;
      ok = 0;
    end else if (oact) begin
      ok++;
    end
    if (ok > 100) oact = 1'b0;
    o_done = oact && (ok == 10);
    if (o_done) oact = 1'b0;
    o_data = 12'h100 + W'(o_chan);
  end

  int fv_cnt = 0;
  int st_cnt = 0;
  bit ov_seen = 1'b0;
  int ov_run = 0;
  int ov_max = 0;
  always @(negedge clk) begin
    if (fv) fv_cnt++;
    if (start) st_cnt++;
    if (rst_n && o_enable) begin
      if (o_busy) begin
        ov_seen = 1'b1;
        ov_run = 0;
      end else if (ov_seen) begin
        ov_run++;
        if (ov_run > ov_max) ov_max = ov_run;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return start;
      1: return start && (chan == 3'd2);
      2: return fv;
      3: return terr;
      4: return !busy;
      5: return busy && (chan == 3'd3) && !start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget,
                          input string tag, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!cond(sel) && cnt < budget);
    if (!cond(sel)) begin
      checks++;
      errors++;
      $error("FAIL %s: observed no event expected one within %0d cycles",
             tag, budget);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) dly[i] = 10;
    base = 12'h100;
    repeat (3) @(negedge clk);

    chk("rst_packed", packed_v, 0);
    chk("rst_current", cur, 0);
    chk("rst_temp", temp, 0);
    chk("rst_valid", fv, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", terr, 0);
    chk("rst_overrun", oerr, 0);
    chk("rst_count", fcnt, 0);
    chk("rst_chan", chan, 0);
    chk("rst_start", start, 0);

    rst_n = 1'b1;
    enable = 1'b1;
    o_enable = 1'b1;

    // clean frame
    wait_for(0, 400, "first_start", n);
    chk("start_lat_min", n >= SP + ST, 1);
    chk("start_lat_max", n <= SP + ST + 1, 1);
    chk("first_chan", chan, 0);
    wait_for(2, 200, "frame1", n);
    chk("frame_latency", n, 87);
    chk("clean_packed", packed_v, 48'h103102101100);
    chk("clean_current", cur, 12'h104);
    chk("clean_temp", temp, 12'h105);
    chk("clean_count", fcnt, 1);
    chk("clean_no_timeout", terr, 0);
    @(negedge clk);
    chk("valid_width", fv, 0);
    chk("valid_pulses", fv_cnt, 1);

    // channel 2 never answers
    dly[2] = 0;
    base = 12'h200;
    wait_for(1, 500, "ch2_start", n);
    wait_for(3, 100, "timeout_flag", n);
    chk("timeout_latency", n, 64);
    chk("err_chan", echan, 2);
    wait_for(0, 50, "ch3_start", n);
    chk("continue_chan", chan, 3);
    wait_for(4, 200, "bad_frame_end", n);
    @(negedge clk);
    chk("bad_no_valid", fv_cnt, 1);
    chk("bad_count", fcnt, 1);
    chk("bad_packed", packed_v, 48'h203102201200);
    chk("bad_current", cur, 12'h204);
    chk("bad_temp", temp, 12'h205);
    chk("main_no_overrun", oerr, 0);

    // overrun instance has been free-running since reset release
    chk("ov_flag", o_oerr, 1);
    chk("ov_frames", o_fcnt >= 3, 1);
    chk("ov_idle_run", ov_max, 1);
    chk("ov_packed", o_packed, 48'h103102101100);
    chk("ov_no_timeout", o_terr, 0);

    // clear, then clear racing a timeout
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_timeout", terr, 0);
    wait_for(1, 500, "ch2_start_b", n);
    clear_err = 1'b1;
    wait_for(3, 100, "timeout_flag_b", n);
    chk("set_beats_clear", terr, 1);
    chk("timeout_latency_b", n, 64);
    clear_err = 1'b0;
    wait_for(4, 200, "bad_frame_end_b", n);
    @(negedge clk);
    chk("bad_no_valid_b", fv_cnt, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    chk("clear_timeout_b", terr, 0);

    // done lands on the final timeout cycle
    dly[2] = 63;
    base = 12'h300;
    wait_for(2, 600, "edge_frame", n);
    chk("edge_no_timeout", terr, 0);
    chk("edge_packed", packed_v, 48'h303302301300);
    chk("edge_current", cur, 12'h304);
    chk("edge_temp", temp, 12'h305);
    chk("edge_count", fcnt, 2);

    // drop enable during channel 3 settle
    dly[2] = 10;
    base = 12'h400;
    wait_for(5, 600, "ch3_settle", n);
    enable = 1'b0;
    n = st_cnt;
    @(negedge clk);
    chk("abort_idle", busy, 0);
    repeat (30) @(negedge clk);
    chk("abort_no_start", st_cnt, n);
    chk("abort_packed", packed_v, 48'h303302301300);
    chk("abort_current", cur, 12'h304);
    chk("abort_count", fcnt, 2);
    chk("abort_no_valid", fv_cnt, 2);
    enable = 1'b1;
    wait_for(0, 400, "reenable_start", n);
    chk("reen_lat_min", n >= SP + ST, 1);
    chk("reen_lat_max", n <= SP + ST + 1, 1);

    // async reset mid-conversion
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_packed", packed_v, 0);
    chk("arst_current", cur, 0);
    chk("arst_count", fcnt, 0);
    chk("arst_busy", busy, 0);
    chk("arst_start", start, 0);
    chk("arst_chan", chan, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_for(0, 400, "post_reset_start", n);
    chk("arst_lat_min", n >= SP + ST, 1);
    chk("arst_lat_max", n <= SP + ST + 1, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
